// File: rtl/mult_control.sv
// mult_control: control sequencer for the 8-bit signed add-shift multiplier.
// Turns the level-sensitive Run / ClearA_LoadB switches into exactly one
// 8-step multiply per Run assertion. Each step is an add-or-skip micro-cycle
// followed by an arithmetic-right-shift micro-cycle. The last step subtracts,
// because the multiplier MSB carries negative weight in two's complement.
//
// Ports:
//   Clk           in   system clock, rising edge
//   Reset         in   synchronous, active-high reset
//   Run           in   start request (level, synchronous to Clk)
//   ClearA_LoadB  in   clear X/A and load B request (level, synchronous)
//   M             in   current multiplier LSB B[0] from the datapath
//   Clr_Ld        out  load B from switches and clear X:A
//   Clr_XA        out  clear X and A at the start of a multiply
//   Add           out  A <= A + S
//   Sub           out  A <= A - S
//   Shift         out  arithmetic right shift of X:A:B
//   Busy          out  multiply in progress
//   Done          out  product valid in A:B, held until Run is released
//   Step          out  current step index k (debug)
//
// Outputs are decoded combinationally from the state. The datapath registers
// them on the same edge that advances this sequencer. Clr_Ld additionally
// depends on ClearA_LoadB, and Add/Sub additionally depend on M.
module mult_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic       M,
  output logic       Clr_Ld,
  output logic       Clr_XA,
  output logic       Add,
  output logic       Sub,
  output logic       Shift,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] Step
);

  localparam int unsigned STEP_W = 3;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(7);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [STEP_W-1:0] k, k_nxt;

  // State and step-counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    Clr_Ld    = 1'b0;
    Clr_XA    = 1'b0;
    Add       = 1'b0;
    Sub       = 1'b0;
    Shift     = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;

    case (state)
      S_IDLE: begin
        // Run has priority, but a simultaneous load still happens this cycle.
        Clr_Ld = ClearA_LoadB;
        if (Run) state_nxt = S_CLR;
      end
      S_CLR: begin
        Busy      = 1'b1;
        Clr_XA    = 1'b1;
        k_nxt     = '0;
        state_nxt = S_ADD;
      end
      S_ADD: begin
        Busy = 1'b1;
        // The final partial product has negative weight.
        if (k == LAST_STEP) Sub = M;
        else                Add = M;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        Busy  = 1'b1;
        Shift = 1'b1;
        if (k == LAST_STEP) begin
          state_nxt = S_HOLD;
        end else begin
          k_nxt     = k + STEP_W'(1);
          state_nxt = S_ADD;
        end
      end
      S_HOLD: begin
        Done   = 1'b1;
        Clr_Ld = ClearA_LoadB;
        // Only a Run release re-arms the sequencer.
        if (!Run) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // While reset is asserted no load may leak through to the datapath.
    if (Reset) Clr_Ld = 1'b0;
  end

  assign Step = k;

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control. A cycle-indexed reference model
// derives the expected strobes from the multiplier operand B. The bench
// drives M from B itself, as the datapath would after k shifts.
module tb_mult_control;

  logic       Clk = 1'b0;
  logic       Reset, Run, ClearA_LoadB, M;
  logic       Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done;
  logic [2:0] Step;

  int checks = 0;
  int errors = 0;

  mult_control dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .Clr_XA       (Clr_XA),
    .Add          (Add),
    .Sub          (Sub),
    .Shift        (Shift),
    .Busy         (Busy),
    .Done         (Done),
    .Step         (Step)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Entered at a falling edge with the DUT idle. Cycle c counts rising edges
  // after the edge that samples Run. abort_at > 0 pulses Reset in that cycle.
  task automatic run_mult(input logic [7:0] b, input int abort_at, input int hold_extra);
    int   n_add = 0, n_sub = 0, n_shift = 0, n_clr = 0;
    int   last;
    logic cl;
    last = (abort_at > 0) ? abort_at : 18 + hold_extra;

    cl = rbit();
    Run = 1'b1; ClearA_LoadB = cl; M = rbit();
    #1;
    chk("idle_clr_ld", 8'(Clr_Ld), 8'(cl));
    chk("idle_busy",   8'(Busy),   8'h0);
    chk("idle_done",   8'(Done),   8'h0);

    for (int c = 1; c <= last; c++) begin
      int   k;
      logic ap;
      @(negedge Clk);
      k  = (c >= 2 && c <= 17) ? (c - 2) / 2 : 7;
      ap = (c >= 2 && c <= 17 && (c % 2) == 0);
      M  = ap ? b[k] : rbit();
      cl = rbit();
      ClearA_LoadB = cl;
      Run = (c < 17) ? rbit() : 1'b1;
      #1;
      chk($sformatf("busy c%0d", c),   8'(Busy),   8'(c >= 1 && c <= 17));
      chk($sformatf("done c%0d", c),   8'(Done),   8'(c >= 18));
      chk($sformatf("clrxa c%0d", c),  8'(Clr_XA), 8'(c == 1));
      chk($sformatf("shift c%0d", c),  8'(Shift),  8'(c >= 3 && c <= 17 && (c % 2) == 1));
      chk($sformatf("add c%0d", c),    8'(Add),    8'(ap && k < 7 && b[k]));
      chk($sformatf("sub c%0d", c),    8'(Sub),    8'(ap && k == 7 && b[k]));
      chk($sformatf("clrld c%0d", c),  8'(Clr_Ld), 8'((c >= 18) && cl));
      if (c >= 2) chk($sformatf("step c%0d", c), 8'(Step), 8'(k));
      n_add   += int'(Add);
      n_sub   += int'(Sub);
      n_shift += int'(Shift);
      n_clr   += int'(Clr_XA);

      if (c == abort_at) begin
        Reset = 1'b1; ClearA_LoadB = 1'b1;
        #1;
        chk("rst_clr_ld_gated", 8'(Clr_Ld), 8'h0);
        @(negedge Clk);
        Reset = 1'b0; Run = 1'b1; cl = rbit(); ClearA_LoadB = cl;
        #1;
        chk("abort_busy",  8'(Busy),   8'h0);
        chk("abort_done",  8'(Done),   8'h0);
        chk("abort_shift", 8'(Shift),  8'h0);
        chk("abort_add",   8'(Add),    8'h0);
        chk("abort_sub",   8'(Sub),    8'h0);
        chk("abort_clrxa", 8'(Clr_XA), 8'h0);
        chk("abort_step",  8'(Step),   8'h0);
        chk("abort_clrld", 8'(Clr_Ld), 8'(cl));
        return;
      end
    end

    chk("n_clrxa", 8'(n_clr),   8'd1);
    chk("n_shift", 8'(n_shift), 8'd8);
    chk("n_add",   8'(n_add),   8'($countones(b[6:0])));
    chk("n_sub",   8'(n_sub),   8'(b[7]));

    // Release Run in HOLD, then one idle cycle before the next start.
    @(negedge Clk);
    Run = 1'b0; cl = rbit(); ClearA_LoadB = cl;
    #1;
    chk("rel_done",  8'(Done),   8'h1);
    chk("rel_clrld", 8'(Clr_Ld), 8'(cl));
    @(negedge Clk);
    cl = rbit(); ClearA_LoadB = cl;
    #1;
    chk("gap_done",  8'(Done),   8'h0);
    chk("gap_busy",  8'(Busy),   8'h0);
    chk("gap_clrld", 8'(Clr_Ld), 8'(cl));
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b1; ClearA_LoadB = 1'b1; M = 1'b1;
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_busy",  8'(Busy),   8'h0);
    chk("rst_done",  8'(Done),   8'h0);
    chk("rst_clrxa", 8'(Clr_XA), 8'h0);
    chk("rst_shift", 8'(Shift),  8'h0);
    chk("rst_add",   8'(Add),    8'h0);
    chk("rst_sub",   8'(Sub),    8'h0);
    chk("rst_clrld", 8'(Clr_Ld), 8'h0);
    chk("rst_step",  8'(Step),   8'h0);

    @(negedge Clk);
    Reset = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b1;
    #1;
    chk("idle_load", 8'(Clr_Ld), 8'h1);
    chk("idle_busy0", 8'(Busy),  8'h0);

    run_mult(8'h05, 0, 3);
    run_mult(8'h80, 0, 0);
    run_mult(8'hFF, 0, 1);
    run_mult(8'($urandom), 7, 0);
    for (int i = 0; i < 6; i++) begin
      run_mult(8'($urandom), 0, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
